axis_video_timing_out: RTL and testbench

- Downstream consumer of the receive-side line buffer's AXI4-Stream pixel output (valid/ready/data/last/sof).
- Regenerates display timing (hsync, vsync, de) from free-running counters in the pixel clock domain.
- Locks the incoming stream to the timing frame on sof, then pulls one pixel per active cycle.
- On underflow or framing error, outputs black, drops lock and resynchronises on the next sof.

---
 rtl/axis_video_timing_out_pkg.sv | 32 +++
 rtl/axis_video_timing_out_if.sv | 22 ++
 rtl/axis_video_timing_out_gen.sv | 72 +++++++
 rtl/axis_video_timing_out.sv | 132 +++++++++++++
 tb/tb_axis_video_timing_out.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_video_timing_out_pkg.sv
// Shared timing constants, counter type and lock-state encoding
// for the video timing output path.
package video_timing_pkg;

  localparam int H_ACTIVE_1080P = 1920;
  localparam int H_FP_1080P     = 88;
  localparam int H_SYNC_1080P   = 44;
  localparam int H_BP_1080P     = 148;
  localparam int V_ACTIVE_1080P = 1080;
  localparam int V_FP_1080P     = 4;
  localparam int V_SYNC_1080P   = 5;
  localparam int V_BP_1080P     = 36;

  localparam int H_TOTAL_1080P =
    H_ACTIVE_1080P + H_FP_1080P +
    H_SYNC_1080P + H_BP_1080P;
  localparam int V_TOTAL_1080P =
    V_ACTIVE_1080P + V_FP_1080P +
    V_SYNC_1080P + V_BP_1080P;

  localparam int RGB_W = 24;

  typedef logic [11:0] vcnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    UNLOCKED,
    ALIGN,
    RUN
  } lock_state_e;

endpackage

// File: rtl/axis_video_timing_out_if.sv
// AXI4-Stream pixel link from the line buffer, with the
// start-of-frame sideband.
interface axis_video_timing_out_if;
  import video_timing_pkg::*;

  logic valid;
  rgb_t data;
  logic last;
  logic sof;
  logic ready;

  modport master (
    output valid, data, last, sof,
    input  ready
  );

  modport slave (
    input  valid, data, last, sof,
    output ready
  );

endinterface

// File: rtl/axis_video_timing_out_gen.sv
// Free-running h/v raster counters with active/sync decode;
// shared between the receive and transmit video paths.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_1080P,
  parameter int H_FP     = H_FP_1080P,
  parameter int H_SYNC   = H_SYNC_1080P,
  parameter int H_BP     = H_BP_1080P,
  parameter int V_ACTIVE = V_ACTIVE_1080P,
  parameter int V_FP     = V_FP_1080P,
  parameter int V_SYNC   = V_SYNC_1080P,
  parameter int V_BP     = V_BP_1080P
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic origin_o,
  output logic line_end_o,
  output logic frame_end_o
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam vcnt_t H_LAST = vcnt_t'(H_TOTAL - 1);
  localparam vcnt_t V_LAST = vcnt_t'(V_TOTAL - 1);
  localparam vcnt_t H_ACT  = vcnt_t'(H_ACTIVE);
  localparam vcnt_t V_ACT  = vcnt_t'(V_ACTIVE);
  localparam vcnt_t HS_BEG = vcnt_t'(H_ACTIVE + H_FP);
  localparam vcnt_t HS_END =
    vcnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vcnt_t VS_BEG = vcnt_t'(V_ACTIVE + V_FP);
  localparam vcnt_t VS_END =
    vcnt_t'(V_ACTIVE + V_FP + V_SYNC);

  vcnt_t h_q, h_d;
  vcnt_t v_q, v_d;
  logic  h_wrap;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + 12'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // vsync depends on v only, so it moves at h == 0
  assign active_o    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_o     = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vsync_o     = (v_q >= VS_BEG) && (v_q < VS_END);
  assign origin_o    = (h_q == '0) && (v_q == '0);
  assign line_end_o  = (h_q == H_ACT - 12'd1);
  assign frame_end_o = h_wrap && (v_q == V_LAST);

endmodule

// File: rtl/axis_video_timing_out.sv
// Locks an AXI4-Stream pixel source to locally generated
// display timing; blanks and relocks on underflow or misframing.
module axis_video_timing_out
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_1080P,
  parameter int H_FP     = H_FP_1080P,
  parameter int H_SYNC   = H_SYNC_1080P,
  parameter int H_BP     = H_BP_1080P,
  parameter int V_ACTIVE = V_ACTIVE_1080P,
  parameter int V_FP     = V_FP_1080P,
  parameter int V_SYNC   = V_SYNC_1080P,
  parameter int V_BP     = V_BP_1080P,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                    i_pclk,
  input  logic                    i_rst_n,
  axis_video_timing_out_if.slave  s_axis,
  output rgb_t                    o_rgb,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic                    o_de,
  output logic                    o_locked,
  output logic                    o_underflow,
  output logic                    o_frame_err
);

  logic active, hsync, vsync;
  logic origin, line_end, frame_end;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_gen (
    .clk_i       (i_pclk),
    .rst_ni      (i_rst_n),
    .active_o    (active),
    .hsync_o     (hsync),
    .vsync_o     (vsync),
    .origin_o    (origin),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  lock_state_e state_q, state_d;
  logic ready, accept, underflow, frame_err;
  logic sof_pix;

  rgb_t rgb_q;
  logic de_q, hs_q, vs_q;
  logic locked_q, uf_q, fe_q;

  assign sof_pix = s_axis.valid && s_axis.sof;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    accept    = 1'b0;
    underflow = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      UNLOCKED: begin
        ready = !sof_pix;
        if (sof_pix) state_d = ALIGN;
      end
      ALIGN: begin
        if (frame_end) state_d = RUN;
      end
      RUN: begin
        if (active) begin
          ready = !(sof_pix && !origin);
          if (!s_axis.valid) begin
            underflow = 1'b1;
            state_d   = UNLOCKED;
          end else if (s_axis.sof && !origin) begin
            // hold the early sof pixel for the next frame
            frame_err = 1'b1;
            state_d   = ALIGN;
          end else begin
            accept = 1'b1;
            if ((s_axis.sof != origin) ||
                (s_axis.last != line_end)) begin
              frame_err = 1'b1;
              state_d   = UNLOCKED;
            end
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  assign s_axis.ready = i_rst_n && ready;

  always_ff @(posedge i_pclk) begin
    if (!i_rst_n) begin
      state_q  <= UNLOCKED;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= !HS_POL;
      vs_q     <= !VS_POL;
      locked_q <= 1'b0;
      uf_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rgb_q    <= accept ? s_axis.data : '0;
      de_q     <= active;
      hs_q     <= hsync ? HS_POL : !HS_POL;
      vs_q     <= vsync ? VS_POL : !VS_POL;
      locked_q <= (state_d == RUN);
      uf_q     <= underflow;
      fe_q     <= frame_err;
    end
  end

  assign o_rgb       = rgb_q;
  assign o_de        = de_q;
  assign o_hsync     = hs_q;
  assign o_vsync     = vs_q;
  assign o_locked    = locked_q;
  assign o_underflow = uf_q;
  assign o_frame_err = fe_q;

endmodule

// File: tb/tb_axis_video_timing_out.sv
// Directed bench on a reduced raster (16x11) with a
// cycle-index reference model and literal anchor checks.
module tb_axis_video_timing_out;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int F   = HT * VT;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] o_rgb;
  logic        o_hsync, o_vsync, o_de;
  logic        o_locked, o_underflow, o_frame_err;

  always #5 clk = ~clk;

  axis_video_timing_out_if s_if ();

  axis_video_timing_out #(
    .H_ACTIVE (HA),  .H_FP (HFP),
    .H_SYNC   (HSW), .H_BP (HBP),
    .V_ACTIVE (VA),  .V_FP (VFP),
    .V_SYNC   (VSW), .V_BP (VBP),
    .HS_POL   (HP),  .VS_POL (VP)
  ) dut (
    .i_pclk      (clk),
    .i_rst_n     (rst_n),
    .s_axis      (s_if),
    .o_rgb       (o_rgb),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_de        (o_de),
    .o_locked    (o_locked),
    .o_underflow (o_underflow),
    .o_frame_err (o_frame_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // model: 0 unlocked, 1 waiting for frame start, 2 running
  int mode, t, fr, gcyc;
  logic [23:0] e_rgb;
  logic e_de, e_hs, e_vs, e_lk, e_uf, e_fe, e_rdy;
  int sf, sl, sp, rst_left;
  bit drop, lflip, act, rdy;
  int h, v;
  int de_cnt, hs_cnt, vs_cnt, run, max_run;
  int de_fall, hs_rise, vs_r1, vs_r2;
  int uf_cnt, fe_cnt;
  logic p_de, p_hs, p_vs;

  initial begin
    sf = 0; sl = 2; sp = 3; rst_left = 4;
    mode = 0; t = 0; fr = 0; gcyc = 0;
    e_rgb = '0; e_de = 0; e_hs = !HP; e_vs = !VP;
    e_lk = 0; e_uf = 0; e_fe = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    run = 0; max_run = 0;
    de_fall = -1; hs_rise = -1; vs_r1 = -1; vs_r2 = -1;
    uf_cnt = 0; fe_cnt = 0;
    p_de = 0; p_hs = 0; p_vs = 0;
    s_if.valid = 0; s_if.data = '0;
    s_if.last = 0; s_if.sof = 0;

    while (fr != 53 && gcyc < 4000) begin
      @(negedge clk);
      if (fr == 9 && t == HT + 4) rst_left = 3;
      rst_n = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      drop  = (fr == 3 && t == 2*HT + 5);
      lflip = (fr == 5 && t == HT + HA - 2);
      if (fr == 7 && t == 3*HT) begin
        sf = 8; sl = 0; sp = 0;
      end
      s_if.valid = !drop;
      s_if.data  = {sf[7:0], sl[7:0], sp[7:0]};
      s_if.sof   = (sl == 0) && (sp == 0);
      s_if.last  = (sp == HA - 1) ^ lflip;
      #1;

      h = t % HT;
      v = t / HT;
      act = (h < HA) && (v < VA);
      if (!rst_n) e_rdy = 0;
      else if (mode == 0) e_rdy = !(s_if.valid && s_if.sof);
      else if (mode == 1) e_rdy = 0;
      else e_rdy = act &&
        !(s_if.valid && s_if.sof && t != 0);

      check("rgb", o_rgb, e_rgb);
      check("de", o_de, e_de);
      check("hsync", o_hsync, e_hs);
      check("vsync", o_vsync, e_vs);
      check("locked", o_locked, e_lk);
      check("underflow", o_underflow, e_uf);
      check("frame_err", o_frame_err, e_fe);
      check("ready", s_if.ready, e_rdy);
      rdy = s_if.ready;

      if (fr == 0 && t == F - 1)
        check("lock_pre", o_locked, 0);
      if (fr == 1 && t == 0)
        check("lock_rise", o_locked, 1);
      if (fr == 1 && t == 1)
        check("first_px", o_rgb, 24'h010000);
      if (fr == 3 && t == 2*HT + 6) begin
        check("uf_pulse", o_underflow, 1);
        check("uf_black", o_rgb, 0);
      end
      if (fr == 3 && t == 2*HT + 7)
        check("uf_unlock", o_locked, 0);
      if (fr == 4 && t == 0)
        check("uf_relock", o_locked, 1);
      if (fr == 5 && t == HT + HA - 1)
        check("last_err", o_frame_err, 1);
      if (fr == 5 && t == HT + HA)
        check("last_unlock", o_locked, 0);
      if (fr == 7 && t == 3*HT + 1)
        check("sof_err", o_frame_err, 1);
      if (fr == 7 && t == 3*HT + 2)
        check("align_rdy", s_if.ready, 0);
      if (fr == 8 && t == 1)
        check("sof_px", o_rgb, 24'h080000);
      if (fr == 50 && !rst_n) begin
        check("rst_rdy", s_if.ready, 0);
        check("rst_lock", o_locked, 0);
        check("rst_hs", o_hsync, !HP);
        check("rst_de", o_de, 0);
      end
      if (fr == 51 && t == 0)
        check("rst_relock", o_locked, 1);

      if (fr == 2) begin
        if (o_de) de_cnt++;
        if (o_hsync == HP) hs_cnt++;
        if (o_vsync == VP) vs_cnt++;
        run = o_de ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (de_fall < 0 && p_de && !o_de) de_fall = t;
        if (de_fall >= 0 && hs_rise < 0 &&
            o_hsync == HP && p_hs != HP) hs_rise = t;
      end
      if ((fr == 1 || fr == 2) && o_vsync == VP &&
          p_vs != VP) begin
        if (vs_r1 < 0) vs_r1 = gcyc;
        else if (vs_r2 < 0) vs_r2 = gcyc;
      end
      if (o_underflow) uf_cnt++;
      if (o_frame_err) fe_cnt++;
      p_de = o_de; p_hs = o_hsync; p_vs = o_vsync;

      @(posedge clk);
      if (!rst_n) begin
        e_rgb = '0; e_de = 0; e_hs = !HP; e_vs = !VP;
        e_lk = 0; e_uf = 0; e_fe = 0;
        mode = 0; t = 0;
        if (fr == 9) fr = 50;
      end else begin
        e_de  = act;
        e_hs  = (h >= HA + HFP && h < HA + HFP + HSW)
                ? HP : !HP;
        e_vs  = (v >= VA + VFP && v < VA + VFP + VSW)
                ? VP : !VP;
        e_rgb = '0; e_uf = 0; e_fe = 0;
        if (mode == 0) begin
          if (s_if.valid && s_if.sof) mode = 1;
        end else if (mode == 1) begin
          if (t == F - 1) mode = 2;
        end else if (act) begin
          if (!s_if.valid) begin
            e_uf = 1; mode = 0;
          end else if (s_if.sof && t != 0) begin
            e_fe = 1; mode = 1;
          end else begin
            e_rgb = s_if.data;
            if (s_if.sof != (t == 0) ||
                s_if.last != (h == HA - 1)) begin
              e_fe = 1; mode = 0;
            end
          end
        end
        e_lk = (mode == 2);
        t++;
        if (t == F) begin
          t = 0; fr++;
        end
      end
      if (s_if.valid && rdy) begin
        sp++;
        if (sp == HA) begin
          sp = 0; sl++;
          if (sl == VA) begin
            sl = 0; sf++;
          end
        end
      end
      gcyc++;
    end

    check("run_end", fr, 53);
    check("de_per_frame", de_cnt, HA * VA);
    check("de_run", max_run, HA);
    check("hs_per_frame", hs_cnt, HSW * VT);
    check("vs_per_frame", vs_cnt, VSW * HT);
    check("de_to_hs", hs_rise - de_fall, HFP);
    check("vs_period", vs_r2 - vs_r1, F);
    check("uf_count", uf_cnt, 1);
    check("fe_count", fe_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
